// File: rtl/add12u_err_monitor.sv
// Error-statistics monitor for a 12-bit approximate unsigned adder.
// Accumulates total, worst-case and count of nonzero |exact-approx| errors over a run.
module add12u_err_monitor #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_samples,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [WIDTH:0]         in_o,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W+WIDTH:0]   err_sum,
  output logic [WIDTH:0]         err_max,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [CNT_W-1:0]       sample_cnt
);

  localparam int SUM_W = CNT_W + WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH:0]     s1_err_q, s1_err_d;
  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH:0]     s2_err_q, s2_err_d;
  logic [SUM_W-1:0]   err_sum_q, err_sum_d;
  logic [WIDTH:0]     err_max_q, err_max_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               xfer;
  logic               clear_acc;
  logic [WIDTH:0]     exact_sum;
  logic [WIDTH:0]     abs_err;
  logic [CNT_W-1:0]   sample_cnt_inc;

  // Exact sum is one bit wider than the operands, so it never wraps.
  always_comb begin
    exact_sum = {1'b0, in_a} + {1'b0, in_b};
    if (exact_sum >= in_o) begin
      abs_err = exact_sum - in_o;
    end else begin
      abs_err = in_o - exact_sum;
    end
  end

  assign xfer           = in_valid && (state_q == ST_RUN);
  assign sample_cnt_inc = sample_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    sample_cnt_d = sample_cnt_q;
    clear_acc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear_acc    = 1'b1;
          sample_cnt_d = '0;
          num_d        = num_samples;
          if (num_samples != '0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          sample_cnt_d = sample_cnt_inc;
          if (sample_cnt_inc == num_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Look at the next-cycle valid bits so DONE lands right after the last accumulate.
        if (!s1_valid_d && !s2_valid_d) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    s1_valid_d = xfer;
    s1_err_d   = xfer ? abs_err : s1_err_q;
    s2_valid_d = s1_valid_q;
    s2_err_d   = s1_valid_q ? s1_err_q : s2_err_q;
    err_sum_d  = err_sum_q;
    err_max_d  = err_max_q;
    err_cnt_d  = err_cnt_q;
    if (clear_acc) begin
      err_sum_d = '0;
      err_max_d = '0;
      err_cnt_d = '0;
    end else if (s2_valid_q) begin
      err_sum_d = err_sum_q + SUM_W'(s2_err_q);
      if (s2_err_q > err_max_q) begin
        err_max_d = s2_err_q;
      end
      if (s2_err_q != '0) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      num_q        <= '0;
      sample_cnt_q <= '0;
      s1_valid_q   <= 1'b0;
      s1_err_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_err_q     <= '0;
      err_sum_q    <= '0;
      err_max_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      sample_cnt_q <= sample_cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_err_q     <= s1_err_d;
      s2_valid_q   <= s2_valid_d;
      s2_err_q     <= s2_err_d;
      err_sum_q    <= err_sum_d;
      err_max_q    <= err_max_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign in_ready   = (state_q == ST_RUN);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err_sum    = err_sum_q;
  assign err_max    = err_max_q;
  assign err_cnt    = err_cnt_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_add12u_err_monitor.sv
// Randomized and directed bench for add12u_err_monitor against a plain-arithmetic model.
module tb_add12u_err_monitor;
  localparam int WIDTH = 12;
  localparam int CNT_W = 24;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [CNT_W-1:0]     num_samples;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [WIDTH:0]       in_o;
  logic                 busy;
  logic                 done;
  logic [CNT_W+WIDTH:0] err_sum;
  logic [WIDTH:0]       err_max;
  logic [CNT_W-1:0]     err_cnt;
  logic [CNT_W-1:0]     sample_cnt;

  int errors = 0;
  int checks = 0;

  int unsigned ta[$];
  int unsigned tbq[$];
  int unsigned toq[$];
  bit          vpat[$];
  bit          inject_start;

  add12u_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(busy), .done(done), .err_sum(err_sum), .err_max(err_max),
    .err_cnt(err_cnt), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic longint ref_err(input int unsigned a, input int unsigned b, input int unsigned o);
    longint ex;
    ex = longint'(a) + longint'(b);
    return (ex > longint'(o)) ? ex - longint'(o) : longint'(o) - ex;
  endfunction

  task automatic clear_triples();
    ta.delete(); tbq.delete(); toq.delete(); vpat.delete();
    inject_start = 1'b0;
  endtask

  task automatic add_triple(input int unsigned a, input int unsigned b, input int unsigned o);
    ta.push_back(a); tbq.push_back(b); toq.push_back(o);
  endtask

  // Runs one measurement starting at a negedge with the monitor idle; ends at a negedge, idle again.
  task automatic do_run(input int n, input int gap_pct, input string name, output int used_cycles);
    longint exp_sum = 0;
    longint exp_max = 0;
    longint e;
    int     exp_cnt = 0;
    int     idx = 0;
    int     cyc = 0;
    bit     v;
    bit     rdy;
    for (int i = 0; i < n; i++) begin
      e = ref_err(ta[i], tbq[i], toq[i]);
      exp_sum += e;
      if (e > exp_max) exp_max = e;
      if (e != 0) exp_cnt++;
    end
    start = 1'b1;
    num_samples = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    num_samples = CNT_W'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: actual=%b required=1", name, busy);
    end
    if (n == 0) begin
      checks++;
      if (done !== 1'b1 || err_sum !== '0 || err_max !== '0 || err_cnt !== '0 || sample_cnt !== '0) begin
        errors++;
        $display("FAIL %s zero_run_done: actual done=%b sum=%0d max=%0d cnt=%0d samples=%0d required done=1 all zero",
                 name, done, err_sum, err_max, err_cnt, sample_cnt);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL %s zero_run_after: actual done=%b busy=%b required 0 0", name, done, busy);
      end
      used_cycles = 1;
      $display("run %s n=0 done sum=%0d max=%0d cnt=%0d", name, err_sum, err_max, err_cnt);
      return;
    end
    while (idx < n && cyc < 2000) begin
      rdy = in_ready;
      checks++;
      if (rdy !== 1'b1) begin
        errors++; $display("FAIL %s ready_in_run: cycle=%0d actual=%b required=1", name, cyc, rdy);
      end
      if (vpat.size() != 0) v = vpat[cyc % vpat.size()];
      else v = ($urandom_range(99) >= gap_pct);
      in_valid = v;
      in_a = v ? WIDTH'(ta[idx]) : WIDTH'($urandom);
      in_b = v ? WIDTH'(tbq[idx]) : WIDTH'($urandom);
      in_o = v ? (WIDTH+1)'(toq[idx]) : (WIDTH+1)'($urandom);
      if (inject_start && idx == 1) begin
        start = 1'b1;
        num_samples = CNT_W'(n + 5);
      end else begin
        start = 1'b0;
      end
      if (v && rdy === 1'b1) idx++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    used_cycles = cyc;
    if (idx < n) begin
      errors++; checks++;
      $display("FAIL %s transfer_timeout: actual=%0d transfers required=%0d", name, idx, n);
      in_valid = 1'b0;
      return;
    end
    // Cycle k+1 after the last transfer: keep offering junk that must not count.
    in_valid = 1'b1;
    in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_o = (WIDTH+1)'($urandom);
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s drain_k1: actual ready=%b done=%b required 0 0", name, in_ready, done);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s drain_k2: actual ready=%b done=%b busy=%b required 0 0 1", name, in_ready, done, busy);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL %s done_k3: actual done=%b busy=%b required 1 1", name, done, busy);
    end
    checks++;
    if (err_sum !== (CNT_W+WIDTH+1)'(exp_sum) || err_max !== (WIDTH+1)'(exp_max) ||
        err_cnt !== CNT_W'(exp_cnt) || sample_cnt !== CNT_W'(n)) begin
      errors++;
      $display("FAIL %s results: actual sum=%0d max=%0d cnt=%0d samples=%0d required sum=%0d max=%0d cnt=%0d samples=%0d",
               name, err_sum, err_max, err_cnt, sample_cnt, exp_sum, exp_max, exp_cnt, n);
    end
    $display("run %s n=%0d cycles=%0d sum=%0d max=%0d cnt=%0d samples=%0d",
             name, n, cyc, err_sum, err_max, err_cnt, sample_cnt);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err_sum !== (CNT_W+WIDTH+1)'(exp_sum) || sample_cnt !== CNT_W'(n)) begin
      errors++;
      $display("FAIL %s hold_after_done: actual done=%b busy=%b sum=%0d samples=%0d required 0 0 %0d %0d",
               name, done, busy, err_sum, sample_cnt, exp_sum, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_o = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err_sum !== '0 ||
        err_max !== '0 || err_cnt !== '0 || sample_cnt !== '0) begin
      errors++;
      $display("FAIL reset_values: actual ready=%b busy=%b done=%b sum=%0d max=%0d cnt=%0d samples=%0d required all 0",
               in_ready, busy, done, err_sum, err_max, err_cnt, sample_cnt);
    end
    in_valid = 1'b1; in_a = 12'd5; in_b = 12'd3; in_o = 13'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || sample_cnt !== '0) begin
        errors++; $display("FAIL idle_no_transfer: actual ready=%b samples=%0d required 0 0", in_ready, sample_cnt);
      end
    end
    in_valid = 1'b0;
    $display("reset and idle done");
  endtask

  task automatic test_exact();
    int c;
    clear_triples();
    add_triple(5, 3, 8); add_triple(4095, 4095, 8190); add_triple(0, 0, 0);
    do_run(3, 0, "exact", c);
    checks++;
    if (err_sum !== '0 || err_cnt !== '0 || sample_cnt !== 24'd3) begin
      errors++; $display("FAIL exact_const: actual sum=%0d cnt=%0d samples=%0d required 0 0 3", err_sum, err_cnt, sample_cnt);
    end
  endtask

  task automatic test_approx();
    int c;
    clear_triples();
    add_triple(15, 1, 8); add_triple(2, 2, 5); add_triple(7, 0, 7); add_triple(0, 0, 8191);
    do_run(4, 0, "approx", c);
    checks++;
    if (err_sum !== 37'd8200 || err_max !== 13'd8191 || err_cnt !== 24'd3) begin
      errors++; $display("FAIL approx_const: actual sum=%0d max=%0d cnt=%0d required 8200 8191 3", err_sum, err_max, err_cnt);
    end
  endtask

  task automatic test_backpressure();
    int c;
    clear_triples();
    add_triple(100, 200, 290); add_triple(4000, 95, 4096);
    vpat.push_back(1'b1); vpat.push_back(1'b0); vpat.push_back(1'b0); vpat.push_back(1'b1);
    do_run(2, 0, "backpressure", c);
    checks++;
    if (c != 4) begin
      errors++; $display("FAIL backpressure_cycles: actual=%0d required=4", c);
    end
  endtask

  task automatic test_zero_and_ignored_start();
    int c;
    clear_triples();
    do_run(0, 0, "zero_len", c);
    clear_triples();
    for (int i = 0; i < 6; i++) add_triple($urandom_range(4095), $urandom_range(4095), $urandom_range(8191));
    inject_start = 1'b1;
    do_run(6, 20, "ignored_start", c);
    inject_start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int c;
    bit saw_done = 1'b0;
    start = 1'b1; num_samples = 24'd1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_a = 12'd15; in_b = 12'd1; in_o = 13'd8;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL midrst_in_drain: actual ready=%b busy=%b required 0 1", in_ready, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || err_sum !== '0 ||
        err_max !== '0 || err_cnt !== '0 || sample_cnt !== '0) begin
      errors++;
      $display("FAIL midrst_cleared: actual busy=%b done=%b sum=%0d max=%0d cnt=%0d samples=%0d required all 0",
               busy, done, err_sum, err_max, err_cnt, sample_cnt);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || err_sum !== '0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL midrst_no_done: actual=done_or_update_seen required=quiet");
    end
    $display("reset mid-run done");
    clear_triples();
    add_triple(15, 1, 8);
    do_run(1, 0, "after_reset", c);
    checks++;
    if (err_sum !== 37'd8 || err_cnt !== 24'd1) begin
      errors++; $display("FAIL after_reset_const: actual sum=%0d cnt=%0d required 8 1", err_sum, err_cnt);
    end
  endtask

  task automatic test_random();
    int c;
    int unsigned a, b, o;
    int signed   d;
    for (int r = 0; r < 3; r++) begin
      clear_triples();
      for (int i = 0; i < 40; i++) begin
        a = $urandom_range(4095);
        b = $urandom_range(4095);
        case ($urandom_range(2))
          0: o = a + b;
          1: begin
            d = int'(a + b) + $urandom_range(64) - 32;
            o = (d < 0) ? 0 : ((d > 8191) ? 8191 : d);
          end
          default: o = $urandom_range(8191);
        endcase
        add_triple(a, b, o);
      end
      do_run(40, (r == 0) ? 0 : 35, "random", c);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    clear_triples();
    add_triple(4095, 4095, 0); add_triple(1, 1, 2);
    do_run(2, 0, "b2b_first", c);
    clear_triples();
    add_triple(10, 20, 31); add_triple(0, 1, 0); add_triple(9, 9, 18);
    do_run(3, 10, "b2b_second", c);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_backpressure();
    test_zero_and_ignored_start();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/add12u_err_monitor.md
# add12u_err_monitor

Streaming error-statistics monitor that sits directly downstream of a 12-bit approximate unsigned adder. Each cycle it accepts the adder's operands and its 13-bit approximate sum, computes the exact sum and the absolute error distance, and accumulates the total absolute error, the worst-case error and the count of erroneous samples over a run of programmable length. Results are held until the next run starts. They feed the MAE/WCE/EP figures quoted for each adder variant.

## Interface
Parameters:
- WIDTH, 12, operand width; the approximate sum is WIDTH+1 bits.
- CNT_W, 24, width of the sample counters; a run covers up to 2^CNT_W-1 samples.

Ports:
- Clocking and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle run request; honoured only in IDLE.
- num_samples  in  CNT_W  run length, sampled when `start` is accepted.
- in_valid  in  1  operand/result triple valid.
- in_ready  out  1  monitor accepts a triple this cycle.
- in_a  in  WIDTH  operand A given to the adder.
- in_b  in  WIDTH  operand B given to the adder.
- in_o  in  WIDTH+1  approximate sum produced by the adder.
- busy  out  1  high from `start` acceptance until `done`, inclusive.
- done  out  1  one-cycle pulse; results are final.
- err_sum  out  CNT_W+WIDTH+1  sum of |exact−approx| over the run.
- err_max  out  WIDTH+1  maximum |exact−approx| over the run.
- err_cnt  out  CNT_W  number of samples with nonzero error.
- sample_cnt  out  CNT_W  number of samples accepted in the current or last run.

## Operation
- Exact sum is a+b, WIDTH+1 bits, zero-extended with no truncation. Error is |exact−in_o|, WIDTH+1 bits, computed as a magnitude of the unsigned difference in either direction.
- Transfer rule: a triple transfers when in_valid && in_ready. in_valid may be held across cycles; only handshaked cycles count.
- The datapath is a 2-stage pipeline:
  - S1 registers the error and a valid bit.
  - S2 updates the accumulators: err_sum += e; err_max = max(err_max, e); err_cnt += (e≠0).
- States:
  - IDLE: in_ready=0.
    - start with num_samples≠0: clear all accumulators and sample_cnt, latch num_samples, go to RUN.
    - start with num_samples=0: clear accumulators, go straight to DONE.
  - RUN: in_ready=1. Each transfer increments sample_cnt. On the transfer that makes sample_cnt==num_samples, go to DRAIN; in_ready drops in the following cycle.
  - DRAIN: in_ready=0. Wait until both pipeline valid bits are 0, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Outputs err_sum, err_max, err_cnt and sample_cnt are held stable from DONE until the next accepted start.
- A start outside IDLE is ignored, with no effect on the run in progress.
- Accumulators cannot overflow by construction, given the widths above. No saturation logic is present.
- rst mid-run aborts the run immediately:
  - state goes to IDLE;
  - pipeline valid bits and all outputs are cleared;
  - no done pulse is produced.

## Timing
- Reset values: in_ready=0, busy=0, done=0, err_sum=0, err_max=0, err_cnt=0, sample_cnt=0, state IDLE.
- Start acceptance at cycle t: busy=1 and in_ready=1 from cycle t+1.
- Error latency: a triple transferred in cycle k is reflected in the accumulators at the end of cycle k+2.
- Last transfer in cycle k: in_ready=0 from cycle k+1, done=1 in cycle k+3, busy=0 from cycle k+4.
- num_samples=0: start at cycle t gives done in cycle t+1, with all results 0.
- Throughput is one triple per clock with no bubbles while in RUN.

## Test plan
- Reset then idle: assert rst for 2 cycles, then release. All outputs read 0. in_valid=1 held in IDLE produces no transfers, and sample_cnt stays 0.
- Exact samples: num_samples=3; triples (5,3,8), (4095,4095,8190), (0,0,0). Expect done 3 cycles after the last transfer with err_sum=0, err_max=0, err_cnt=0, sample_cnt=3.
- Approximate errors: num_samples=4; triples (15,1,8) giving e=8, (2,2,5) giving e=1, (7,0,7) giving e=0, and (0,0,8191) giving e=8191. Expect err_sum=8200, err_max=8191, err_cnt=3.
- Backpressure and gaps: num_samples=2 with in_valid toggling 1,0,0,1. Only 2 transfers are counted. in_ready=0 one cycle after the second transfer. Extra valid triples after that are not counted.
- Zero-length run and ignored start: start with num_samples=0 gives done in the next cycle with zeros. A start pulse in mid-RUN leaves sample_cnt and num_samples unaffected.
- Reset mid-run: rst asserted during DRAIN with one sample in flight. No done pulse, all outputs 0. A subsequent run of 1 sample (15,1,8) gives err_sum=8, err_cnt=1.
